bldc_run_sequencer: RTL and testbench

Run-sequence controller placed ahead of `bldc_esc_1`: it owns the ESC's `reset`, `pwm_en` and `period_reference` inputs.

- Turns start/stop commands and a signed target period into an arm, soft-ramp, run, coast and fault sequence.
- Ramps the commanded period magnitude one step per tick, so the PID never sees a step reference.
- Coasts the motor before every direction reversal.
- Drops the bridge when encoder A stops toggling (stall).

---
 rtl/bldc_run_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_bldc_run_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_run_sequencer.sv
// Run-sequence controller ahead of bldc_esc_1: arm, soft ramp, run, coast-before-reverse and stall fault.
// Define BLDC_SEQ_STALL_EN to build encoder stall detection and the FAULT entry path.
`timescale 1ns/1ps
module bldc_run_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int PRESCALE    = 1000,
  parameter int START_MAG   = 4000,
  parameter int STALL_TICKS = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear_fault,
  input  logic [DATA_WIDTH-1:0] target_ref,
  input  logic [7:0]            ramp_step,
  input  logic [7:0]            coast_ticks,
  input  logic                  enc_a,
  output logic                  esc_reset,
  output logic                  pwm_en,
  output logic [DATA_WIDTH-1:0] period_reference,
  output logic                  busy,
  output logic                  fault,
  output logic [2:0]            state
);
  localparam int W  = DATA_WIDTH;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  START_V    = W'(START_MAG);
  // Largest magnitude that still encodes on the correct side of the ESC sign threshold.
  localparam logic [W-1:0]  MAG_MAX    = {1'b0, {(W-2){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_COAST = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick;
  logic [W-1:0]   mag_q, mag_d;
  logic           dir_q, dir_d;
  logic           rev_q, rev_d;
  logic [1:0]     arm_q, arm_d;
  logic [7:0]     coast_q, coast_d;
  logic [7:0]     coast_len;
  logic [W-1:0]   period_q, period_d;
  logic           esc_reset_q, pwm_en_q, busy_q, fault_q;
  logic           stall_fault;
  logic           stall_clr;

  logic [W-1:0]   tgt_abs, mag_t;
  logic           dir_t, stop_req;
  logic [W-1:0]   step, diff, delta, mag_ramp;
  logic           ramp_down;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_comb begin
    tgt_abs = target_ref[W-1] ? (~target_ref + 1'b1) : target_ref;
    mag_t   = (tgt_abs > MAG_MAX) ? MAG_MAX : tgt_abs;
  end

  assign dir_t    = target_ref[W-1];
  assign stop_req = stop || (mag_t == '0);

  always_comb begin
    step      = (ramp_step == 8'd0) ? W'(1) : W'(ramp_step);
    ramp_down = (mag_q > mag_t);
    diff      = ramp_down ? (mag_q - mag_t) : (mag_t - mag_q);
    delta     = (step < diff) ? step : diff;
    mag_ramp  = ramp_down ? (mag_q - delta) : (mag_q + delta);
  end

  assign coast_len = (coast_ticks == 8'd0) ? 8'd1 : coast_ticks;

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    dir_d     = dir_q;
    rev_d     = rev_q;
    arm_d     = arm_q;
    coast_d   = coast_q;
    stall_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && (mag_t != '0)) begin
          state_d = S_ARM;
          dir_d   = dir_t;
          arm_d   = 2'd0;
        end
      end
      S_ARM: begin
        if (stop_req) begin
          state_d = S_COAST;
          rev_d   = 1'b0;
          coast_d = coast_len;
        end else if (arm_q == 2'd3) begin
          state_d   = S_RAMP;
          stall_clr = 1'b1;
        end else begin
          arm_d = arm_q + 1'b1;
        end
      end
      S_RAMP: begin
        if (stall_fault) begin
          state_d = S_FAULT;
        end else if (stop_req) begin
          state_d = S_COAST;
          rev_d   = 1'b0;
          coast_d = coast_len;
        end else if (mag_q == mag_t) begin
          state_d = S_RUN;
        end else if (tick) begin
          mag_d = mag_ramp;
        end
      end
      S_RUN: begin
        if (stall_fault) begin
          state_d = S_FAULT;
        end else if (stop_req) begin
          state_d = S_COAST;
          rev_d   = 1'b0;
          coast_d = coast_len;
        end else if (dir_t != dir_q) begin
          state_d = S_COAST;
          rev_d   = 1'b1;
          coast_d = coast_len;
        end else if (mag_t != mag_q) begin
          state_d = S_RAMP;
        end
      end
      S_COAST: begin
        // A stop arriving during a reversal coast turns it into a plain stop.
        rev_d = rev_q && !stop_req;
        if (tick) begin
          if (coast_q <= 8'd1) begin
            if (rev_d) begin
              state_d   = S_RAMP;
              dir_d     = dir_t;
              mag_d     = START_V;
              stall_clr = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            coast_d = coast_q - 1'b1;
          end
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      mag_d = START_V;
      dir_d = 1'b0;
      rev_d = 1'b0;
    end
    period_d = dir_d ? (~mag_d + 1'b1) : mag_d;
  end

`ifdef BLDC_SEQ_STALL_EN
  localparam bit STALL_BUILT = 1'b1;
  localparam int SW = $clog2(STALL_TICKS + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_TICKS);

  logic [2:0]    enc_sync_q;
  logic [SW-1:0] stall_q, stall_d, stall_inc;
  logic          enc_rise, in_drive;

  // Bits 0/1 form the synchronizer; bit 2 is the previous synchronized value.
  assign enc_rise = enc_sync_q[1] & ~enc_sync_q[2];
  assign in_drive = (state_q == S_RAMP) || (state_q == S_RUN);

  always_comb begin
    stall_inc = stall_q;
    if (enc_rise) begin
      stall_inc = '0;
    end else if (tick && in_drive && (stall_q != STALL_MAX)) begin
      stall_inc = stall_q + 1'b1;
    end
    stall_d = stall_clr ? '0 : stall_inc;
  end

  assign stall_fault = in_drive && (stall_inc == STALL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_sync_q <= '0;
      stall_q    <= '0;
    end else begin
      enc_sync_q <= {enc_sync_q[1:0], enc_a};
      stall_q    <= stall_d;
    end
  end
`else
  localparam bit STALL_BUILT = 1'b0;
  logic unused_stall_cfg;
  assign stall_fault      = 1'b0;
  assign unused_stall_cfg = enc_a ^ stall_clr ^ (STALL_TICKS == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      mag_q       <= START_V;
      dir_q       <= 1'b0;
      rev_q       <= 1'b0;
      arm_q       <= 2'd0;
      coast_q     <= 8'd0;
      period_q    <= START_V;
      esc_reset_q <= 1'b1;
      pwm_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      mag_q       <= mag_d;
      dir_q       <= dir_d;
      rev_q       <= rev_d;
      arm_q       <= arm_d;
      coast_q     <= coast_d;
      period_q    <= period_d;
      esc_reset_q <= (state_d == S_IDLE) || (state_d == S_FAULT);
      pwm_en_q    <= (state_d == S_RAMP) || (state_d == S_RUN);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_FAULT);
      fault_q     <= STALL_BUILT && (state_d == S_FAULT);
    end
  end

  assign esc_reset        = esc_reset_q;
  assign pwm_en           = pwm_en_q;
  assign period_reference = period_q;
  assign busy             = busy_q;
  assign fault            = fault_q;
  assign state            = state_q;
endmodule

// File: tb/tb_bldc_run_sequencer.sv
// Scoreboard bench for bldc_run_sequencer: a signed-period reference model predicts every cycle's outputs.
`timescale 1ns/100ps
module tb_bldc_run_sequencer;
  localparam int PRESCALE    = 4;
  localparam int START_MAG   = 4000;
  localparam int STALL_TICKS = 200;
`ifdef BLDC_SEQ_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif
  localparam int P_IDLE = 0, P_ARM = 1, P_RAMP = 2, P_RUN = 3, P_COAST = 4, P_FAULT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear_fault = 1'b0, enc_a = 1'b0;
  logic [15:0] target_ref = 16'd1000;
  logic [7:0]  ramp_step = 8'd100, coast_ticks = 8'd5;
  logic        esc_reset, pwm_en, busy, fault;
  logic [15:0] period_reference;
  logic [2:0]  state;
  int          enc_mode = 1;
  int          checks = 0, errors = 0;

  bldc_run_sequencer #(
    .DATA_WIDTH(16), .PRESCALE(PRESCALE), .START_MAG(START_MAG), .STALL_TICKS(STALL_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear_fault(clear_fault),
    .target_ref(target_ref), .ramp_step(ramp_step), .coast_ticks(coast_ticks), .enc_a(enc_a),
    .esc_reset(esc_reset), .pwm_en(pwm_en), .period_reference(period_reference),
    .busy(busy), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: signed period command, phase, and tick/coast/stall counts as plain integers.
  int  m_phase, m_ref, m_arm_left, m_coast_left, m_k, m_stall;
  bit  m_rev;
  bit  m_enc[3];
  logic [22:0] exp_q[$];

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_ref = START_MAG; m_rev = 1'b0;
    m_arm_left = 0; m_coast_left = 0; m_k = 0; m_stall = 0;
    m_enc[0] = 1'b0; m_enc[1] = 1'b0; m_enc[2] = 1'b0;
  endtask

  task automatic go_coast(input bit r);
    m_phase = P_COAST;
    m_rev = r;
    m_coast_left = (coast_ticks == 8'd0) ? 1 : int'(coast_ticks);
  endtask

  task automatic model_step();
    bit tk, td, stopr, drive, rise, trip, dir;
    int tm, mag, st, stall_next;
    tk = ((m_k % PRESCALE) == PRESCALE - 1);
    m_k++;
    tm = abs_i(int'($signed(target_ref)));
    if (tm > 32766) tm = 32766;
    td = target_ref[15];
    stopr = stop || (tm == 0);
    mag = abs_i(m_ref);
    dir = (m_ref < 0);
    drive = (m_phase == P_RAMP) || (m_phase == P_RUN);
    rise = m_enc[1] && !m_enc[2];
    m_enc[2] = m_enc[1]; m_enc[1] = m_enc[0]; m_enc[0] = enc_a;
    stall_next = rise ? 0 : ((tk && drive && m_stall < STALL_TICKS) ? m_stall + 1 : m_stall);
    trip = STALL_ON && drive && (stall_next >= STALL_TICKS);
    m_stall = stall_next;
    st = (ramp_step == 8'd0) ? 1 : int'(ramp_step);
    case (m_phase)
      P_IDLE: begin
        if (start && !stop && tm != 0) begin
          m_phase = P_ARM; m_arm_left = 4;
          m_ref = td ? -START_MAG : START_MAG;
        end
      end
      P_ARM: begin
        if (stopr) go_coast(1'b0);
        else begin
          m_arm_left--;
          if (m_arm_left == 0) begin m_phase = P_RAMP; m_stall = 0; end
        end
      end
      P_RAMP: begin
        if (trip) m_phase = P_FAULT;
        else if (stopr) go_coast(1'b0);
        else if (mag == tm) m_phase = P_RUN;
        else if (tk) begin
          mag = (mag > tm) ? mag - min_i(st, mag - tm) : mag + min_i(st, tm - mag);
          m_ref = dir ? -mag : mag;
        end
      end
      P_RUN: begin
        if (trip) m_phase = P_FAULT;
        else if (stopr) go_coast(1'b0);
        else if (td != dir) go_coast(1'b1);
        else if (tm != mag) m_phase = P_RAMP;
      end
      P_COAST: begin
        if (stopr) m_rev = 1'b0;
        if (tk) begin
          m_coast_left--;
          if (m_coast_left <= 0) begin
            if (m_rev) begin
              m_phase = P_RAMP; m_stall = 0;
              m_ref = td ? -START_MAG : START_MAG;
            end else m_phase = P_IDLE;
          end
        end
      end
      default: if (clear_fault) m_phase = P_IDLE;
    endcase
    if (m_phase == P_IDLE) begin m_ref = START_MAG; m_rev = 1'b0; end
  endtask

  function automatic logic [22:0] exp_vec();
    bit e_rst, e_pwm, e_busy, e_flt;
    e_rst  = (m_phase == P_IDLE) || (m_phase == P_FAULT);
    e_pwm  = (m_phase == P_RAMP) || (m_phase == P_RUN);
    e_busy = !e_rst;
    e_flt  = (m_phase == P_FAULT);
    return {3'(m_phase), e_rst, e_pwm, e_busy, e_flt, 16'(m_ref)};
  endfunction

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    exp_q.push_back(exp_vec());
  end

  // Monitor: the outputs are registered, so one expectation is due every cycle.
  always @(posedge clk) begin
    logic [22:0] e, a;
    #1;
    a = {state, esc_reset, pwm_en, busy, fault, period_reference};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty at %0t: no expectation queued", $time);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL cycle_out at %0t: got state %0d esc %b pwm %b busy %b fault %b period %h, required state %0d esc %b pwm %b busy %b fault %b period %h",
                   $time, a[22:20], a[19], a[18], a[17], a[16], a[15:0],
                   e[22:20], e[19], e[18], e[17], e[16], e[15:0]);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (enc_mode)
        1: enc_a = ~enc_a;
        2: enc_a = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic wait_for(input logic [2:0] s, input logic [15:0] p, input bit use_p,
                          input int max_cyc, input string name);
    int n = 0;
    while (!(state == s && (!use_p || period_reference == p)) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s: timeout with state %0d period %h, required state %0d", name, state, period_reference, s);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] rand_target();
    int r, m;
    r = $urandom_range(0, 11);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'h8000;
    if (r == 2) return 16'h7FFF;
    m = $urandom_range(3000, 5000);
    return ($urandom_range(0, 1) == 1) ? 16'(-m) : 16'(m);
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_esc", 32'(esc_reset), 32'd1);
    chk("reset_pwm", 32'(pwm_en), 32'd0);
    chk("reset_period", 32'(period_reference), 32'd4000);
    chk("reset_busy_fault", 32'({busy, fault}), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("test 1: forward soft start to 1000");
    pulse_start();
    chk("t1_arm", 32'(state), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_arm_pwm_low", 32'(pwm_en), 32'd0);
    @(negedge clk);
    chk("t1_pwm_rise", 32'(pwm_en), 32'd1);
    chk("t1_ramp_start", 32'(period_reference), 32'd4000);
    wait_for(3'd3, 16'd1000, 1'b1, 200, "t1_run");
    chk("t1_run_pwm", 32'(pwm_en), 32'd1);

    $display("test 2: reversal through coast");
    target_ref = 16'hFC18;
    wait_for(3'd4, 16'h0, 1'b0, 10, "t2_coast");
    chk("t2_coast_outputs", 32'({esc_reset, pwm_en}), 32'd0);
    wait_for(3'd2, 16'h0, 1'b0, 40, "t2_ramp");
    chk("t2_restart_mag", 32'(period_reference), 32'h0000F060);
    wait_for(3'd3, 16'hFC18, 1'b1, 200, "t2_run");

    $display("test 6: ramp_step 0 acts as 1");
    stop = 1'b1;
    wait_for(3'd0, 16'h0, 1'b0, 40, "t6_idle");
    stop = 1'b0;
    target_ref = 16'd3998;
    ramp_step = 8'd0;
    pulse_start();
    wait_for(3'd3, 16'd3998, 1'b1, 60, "t6_run");

    $display("test 4: stop wins over sign change");
    stop = 1'b1;
    target_ref = 16'hF062;
    @(negedge clk);
    chk("t4_coast", 32'(state), 32'd4);
    stop = 1'b0;
    wait_for(3'd0, 16'h0, 1'b0, 60, "t4_idle");

    $display("test 5: asynchronous reset mid-ramp");
    target_ref = 16'd1000;
    ramp_step = 8'd100;
    pulse_start();
    wait_for(3'd2, 16'h0, 1'b0, 20, "t5_ramp");
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #0.5;
    chk("t5_pwm", 32'(pwm_en), 32'd0);
    chk("t5_esc", 32'(esc_reset), 32'd1);
    chk("t5_period", 32'(period_reference), 32'd4000);
    chk("t5_state", 32'(state), 32'd0);
    #0.5 rst_n = 1'b1;
    @(negedge clk);

    if (STALL_ON) begin
      $display("test 3: stall fault and clear");
      enc_mode = 0;
      enc_a = 1'b0;
      pulse_start();
      wait_for(3'd5, 16'h0, 1'b0, STALL_TICKS * PRESCALE + 100, "t3_fault");
      chk("t3_fault_outputs", 32'({esc_reset, fault, pwm_en}), 32'b110);
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
      chk("t3_cleared", 32'({state, fault}), 32'd0);
      enc_mode = 1;
    end

    $display("random phase");
    enc_mode = 2;
    for (int i = 0; i < 200; i++) begin
      target_ref  = rand_target();
      ramp_step   = 8'($urandom_range(0, 255));
      coast_ticks = 8'($urandom_range(0, 4));
      start       = ($urandom_range(0, 2) != 0);
      stop        = ($urandom_range(0, 9) == 0);
      clear_fault = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    start = 1'b0;
    stop = 1'b0;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
